// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter
//
// Shares one external read port between three memory clients:
//   client 0 = instruction fetch (fixed top priority)
//   client 1 = input-feature load
//   client 2 = weight load
// Clients 1 and 2 share the remaining bandwidth round-robin. An accepted
// burst issues one read per cycle on the shared port, and the returned data
// is tagged to the owning client with rd_valid/rd_done strobes.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   req_valid[x]        client x requests a burst
//   req_addr            packed per-client start word address (x*ADDR_WIDTH +: ADDR_WIDTH)
//   req_len             packed per-client beats-minus-one (x*LEN_WIDTH +: LEN_WIDTH)
//   req_ready[x]        combinational grant; request accepted on valid & ready
//   rd_valid[x]         rd_data belongs to client x this cycle
//   rd_done[x]          pulse with the last returned beat of client x's burst
//   rd_data             shared return data, wired straight from mem_rdata
//   mem_rd_en/mem_addr  shared port read request
//   mem_rdata           shared port read data, valid one cycle after mem_rd_en
//   busy                high whenever the arbiter is not idle

module ddr_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [2:0]                req_valid,
    input  logic [3*ADDR_WIDTH-1:0]   req_addr,
    input  logic [3*LEN_WIDTH-1:0]    req_len,
    output logic [2:0]                req_ready,

    output logic [2:0]                rd_valid,
    output logic [2:0]                rd_done,
    output logic [DATA_WIDTH-1:0]     rd_data,

    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,

    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                  state_q;

    // rr_q == 0: feature wins the next feature/weight tie, 1: weight wins.
    logic                    rr_q;

    logic [1:0]              owner_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_q;

    logic                    mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    busy_q;
    logic [2:0]              rd_valid_q;
    logic [2:0]              rd_done_q;

    // Combinational arbitration result for the current IDLE cycle.
    logic                    grant_d;
    logic [1:0]              grant_idx_d;
    logic [ADDR_WIDTH-1:0]   grant_addr_d;
    logic [LEN_WIDTH-1:0]    grant_len_d;

    logic                    last_beat;

    //--------------------------------------------------------------------
    // Arbitration. Only evaluated in IDLE; a grant during reset would be
    // discarded by the reset branch, so ready is suppressed there as well.
    //--------------------------------------------------------------------
    always_comb begin
        grant_d     = 1'b0;
        grant_idx_d = 2'd0;
        if (state_q == IDLE && !rst) begin
            if (req_valid[0]) begin
                grant_d     = 1'b1;
                grant_idx_d = 2'd0;
            end else if (req_valid[1] && req_valid[2]) begin
                grant_d     = 1'b1;
                grant_idx_d = rr_q ? 2'd2 : 2'd1;
            end else if (req_valid[1]) begin
                grant_d     = 1'b1;
                grant_idx_d = 2'd1;
            end else if (req_valid[2]) begin
                grant_d     = 1'b1;
                grant_idx_d = 2'd2;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_d) begin
            req_ready = 3'b001 << grant_idx_d;
        end
    end

    // Select the granted client's address/length fields.
    always_comb begin
        grant_addr_d = '0;
        grant_len_d  = '0;
        case (grant_idx_d)
            2'd0: begin
                grant_addr_d = req_addr[0*ADDR_WIDTH +: ADDR_WIDTH];
                grant_len_d  = req_len[0*LEN_WIDTH +: LEN_WIDTH];
            end
            2'd1: begin
                grant_addr_d = req_addr[1*ADDR_WIDTH +: ADDR_WIDTH];
                grant_len_d  = req_len[1*LEN_WIDTH +: LEN_WIDTH];
            end
            2'd2: begin
                grant_addr_d = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
                grant_len_d  = req_len[2*LEN_WIDTH +: LEN_WIDTH];
            end
            default: begin
                grant_addr_d = '0;
                grant_len_d  = '0;
            end
        endcase
    end

    assign last_beat = (beat_q == len_q);

    //--------------------------------------------------------------------
    // Control FSM and registered outputs.
    // mem_rd_en_q is high exactly while in BURST, so the return-path
    // strobes are derived from the BURST state one cycle earlier.
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 2'd0;
            len_q       <= '0;
            beat_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            rd_valid_q  <= '0;
            rd_done_q   <= '0;
        end else begin
            // Return path: one cycle behind the issued read.
            rd_valid_q <= (state_q == BURST) ? (3'b001 << owner_q) : 3'b000;
            rd_done_q  <= (state_q == BURST && last_beat) ? (3'b001 << owner_q) : 3'b000;

            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= BURST;
                        owner_q     <= grant_idx_d;
                        len_q       <= grant_len_d;
                        beat_q      <= '0;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= grant_addr_d;
                        busy_q      <= 1'b1;
                        // Instruction grants leave the feature/weight order alone.
                        if (grant_idx_d != 2'd0) begin
                            rr_q <= (grant_idx_d == 2'd1);
                        end
                    end
                end

                BURST: begin
                    if (last_beat) begin
                        state_q     <= DRAIN;
                        beat_q      <= '0;
                        mem_rd_en_q <= 1'b0;
                    end else begin
                        beat_q     <= beat_q + 1'b1;
                        // Wraps naturally at the top of the address space.
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                end

                DRAIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q     <= IDLE;
                    mem_rd_en_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_done   = rd_done_q;
    assign rd_data   = mem_rdata;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Testbench for ddr_read_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level schedule model.

module tb_ddr_read_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 128;
    localparam int unsigned LW = 4;
    localparam int unsigned RING = 64;

    logic            clk;
    logic            rst;
    logic [2:0]      req_valid;
    logic [3*AW-1:0] req_addr;
    logic [3*LW-1:0] req_len;
    logic [2:0]      req_ready;
    logic [2:0]      rd_valid;
    logic [2:0]      rd_done;
    logic [DW-1:0]   rd_data;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    ddr_read_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed hash of the word address.
    function automatic logic [127:0] memf(input logic [15:0] a);
        logic [31:0] h;
        h = {a, ~a} * 32'h9E3779B1;
        return {h, h ^ 32'hDEADBEEF, ~h, h + 32'd1 + {16'd0, a}};
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? memf(mem_addr) : '0;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    //--------------------------------------------------------------------
    // Reference model: each grant writes its whole future timeline
    // (read issue, data return, done, busy) into a cycle-indexed ring.
    //--------------------------------------------------------------------
    bit          s_en   [RING];
    bit          s_achk [RING];
    logic [15:0] s_addr [RING];
    logic [2:0]  s_v    [RING];
    logic [2:0]  s_d    [RING];
    logic [15:0] s_daddr[RING];
    bit          s_busy [RING];
    int unsigned next_free = 0;
    bit          rr_w = 1'b0;   // 1: weight wins next feature/weight tie

    task automatic clear_slot(input int unsigned i);
        s_en[i] = 0; s_achk[i] = 0; s_addr[i] = '0;
        s_v[i] = '0; s_d[i] = '0; s_daddr[i] = '0; s_busy[i] = 0;
    endtask

    task automatic model_step();
        int unsigned s;
        int          g;
        logic [2:0]  exp_rdy;
        logic [15:0] base;
        int unsigned len;
        s = cyc % RING;

        check("mem_rd_en", {127'd0, mem_rd_en}, {127'd0, s_en[s]});
        if (s_achk[s]) check("mem_addr", {112'd0, mem_addr}, {112'd0, s_addr[s]});
        check("rd_valid", {125'd0, rd_valid}, {125'd0, s_v[s]});
        check("rd_done", {125'd0, rd_done}, {125'd0, s_d[s]});
        check("busy", {127'd0, busy}, {127'd0, s_busy[s]});
        if (s_v[s] != 3'b000) check("rd_data", rd_data, memf(s_daddr[s]));
        clear_slot(s);

        exp_rdy = 3'b000;
        if (rst) begin
            for (int unsigned i = 0; i < RING; i++) clear_slot(i);
            s_achk[(cyc + 1) % RING] = 1;
            s_addr[(cyc + 1) % RING] = '0;
            next_free = cyc + 1;
            rr_w = 1'b0;
        end else if (cyc >= next_free) begin
            g = -1;
            if (req_valid[0]) g = 0;
            else if (req_valid[1] && req_valid[2]) g = rr_w ? 2 : 1;
            else if (req_valid[1]) g = 1;
            else if (req_valid[2]) g = 2;
            if (g >= 0) begin
                exp_rdy = 3'b001 << g;
                base = req_addr[g*16 +: 16];
                len  = int'(req_len[g*4 +: 4]);
                for (int unsigned k = 0; k <= len; k++) begin
                    s_en  [(cyc + 1 + k) % RING] = 1;
                    s_achk[(cyc + 1 + k) % RING] = 1;
                    s_addr[(cyc + 1 + k) % RING] = base + 16'(k);
                    s_v   [(cyc + 2 + k) % RING] = 3'b001 << g;
                    s_daddr[(cyc + 2 + k) % RING] = base + 16'(k);
                end
                s_d[(cyc + 2 + len) % RING] = 3'b001 << g;
                for (int unsigned k = 1; k <= len + 2; k++) s_busy[(cyc + k) % RING] = 1;
                next_free = cyc + 3 + len;
                if (g == 1) rr_w = 1'b1;
                if (g == 2) rr_w = 1'b0;
            end
        end
        check("req_ready", {125'd0, req_ready}, {125'd0, exp_rdy});
        cyc++;
    endtask

    //--------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------
    logic [2:0]      v_s;
    logic [3*AW-1:0] a_s;
    logic [3*LW-1:0] l_s;
    logic            r_s;
    logic [2:0]      rdy_s;

    task automatic tick();
        req_valid = v_s; req_addr = a_s; req_len = l_s; rst = r_s;
        @(negedge clk);
        rdy_s = req_ready;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        v_s = 3'b000;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int x, input logic [15:0] a, input logic [3:0] l);
        v_s[x] = 1'b1;
        a_s[x*16 +: 16] = a;
        l_s[x*4 +: 4] = l;
    endtask

    // Hold the pending requests, dropping each client once it is accepted.
    task automatic run_until_drained(input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc && v_s != 3'b000; i++) begin
            tick();
            v_s = v_s & ~rdy_s;
        end
        if (v_s != 3'b000) begin
            check("accept_timeout", {125'd0, v_s}, 128'd0);
            v_s = 3'b000;
        end
    endtask

    initial begin
        v_s = '0; a_s = '0; l_s = '0; r_s = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r_s = 1'b0;
        s_achk[0] = 1; s_addr[0] = '0;

        // Reset state and a single instruction read.
        idle(2);
        set_req(0, 16'h0010, 4'd0);
        run_until_drained(10);
        idle(4);

        // Three simultaneous requests.
        set_req(0, 16'h0100, 4'd1);
        set_req(1, 16'h0200, 4'd3);
        set_req(2, 16'h0300, 4'd3);
        run_until_drained(40);
        idle(8);

        // Round-robin with continuous feature/weight, one instr inserted.
        set_req(1, 16'h0400, 4'd0);
        set_req(2, 16'h0500, 4'd0);
        for (int unsigned i = 0; i < 20; i++) begin
            if (i == 7) v_s[0] = 1'b1;
            tick();
            v_s[0] = v_s[0] & ~rdy_s[0];
        end
        idle(6);

        // Address wrap.
        set_req(1, 16'hFFFE, 4'd3);
        run_until_drained(10);
        idle(8);

        // Reset in the middle of a long weight burst.
        set_req(2, 16'h0800, 4'd15);
        run_until_drained(10);
        for (int unsigned i = 0; i < 5; i++) tick();
        r_s = 1'b1;
        tick();
        r_s = 1'b0;
        idle(20);
        set_req(1, 16'h0900, 4'd2);
        set_req(2, 16'h0A00, 4'd2);
        run_until_drained(20);
        idle(8);

        // Request fields change right after the handshake.
        set_req(1, 16'h1234, 4'd2);
        run_until_drained(10);
        a_s[16 +: 16] = 16'hBEEF;
        l_s[4 +: 4] = 4'd9;
        idle(8);

        // Random traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            for (int x = 0; x < 3; x++) begin
                if (!v_s[x]) begin
                    a_s[x*16 +: 16] = 16'($urandom);
                    l_s[x*4 +: 4]   = 4'($urandom);
                    if ($urandom_range(0, (x == 0) ? 7 : 3) == 0) begin
                        v_s[x] = 1'b1;
                        if ($urandom_range(0, 7) == 0)
                            a_s[x*16 +: 16] = 16'hFFF0 | 16'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v_s[x] = 1'b0;
                end
            end
            r_s = ($urandom_range(0, 299) == 0);
            tick();
            v_s = v_s & ~rdy_s;
        end
        r_s = 1'b0;
        idle(25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
